// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op and state
// encodings, iteration counts and small arithmetic helpers.
package muldiv_hilo_pkg;

    // Operation encodings as presented on req_op.
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } md_op_e;

    // Controller states; also exported on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_ITERS = 32;
    // Wide enough to count a setup cycle plus up to 32 iterations.
    localparam int unsigned CNT_W     = 6;

    // Number of shift-add iterations for a given radix (bits per iteration).
    function automatic int unsigned mul_iters(input int unsigned radix_bits);
        return XLEN / radix_bits;
    endfunction

    // Absolute value of a 32-bit operand when the op is signed; raw otherwise.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate of a 64-bit value. In full mode the
// whole word is negated under neg_lo (a product); in split mode each 32-bit
// half is negated independently (remainder in the high half, quotient low).
module muldiv_signfix (
    input  logic        split,
    input  logic        neg_hi,
    input  logic        neg_lo,
    input  logic [63:0] din,
    output logic [63:0] dout
);

    logic [63:0] neg_full;
    logic [31:0] neg_h;
    logic [31:0] neg_l;

    // Select negated or pass-through value per half / full word.
    always_comb begin
        neg_full = ~din + 64'd1;
        neg_h    = ~din[63:32] + 32'd1;
        neg_l    = ~din[31:0] + 32'd1;
        dout     = din;
        if (!split) begin
            dout = neg_lo ? neg_full : din;
        end else begin
            dout[63:32] = neg_hi ? neg_h : din[63:32];
            dout[31:0]  = neg_lo ? neg_l : din[31:0];
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit feeding the HI/LO register block.
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE without cancel.
// Each operation spends one setup cycle forming operand magnitudes, then
// the iterations, then a single DONE cycle that pulses we_HI/we_LO.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int unsigned MUL_RADIX_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        cancel,
    output logic        busy,
    output logic        we_HI,
    output logic        we_LO,
    output logic [31:0] wd_HI,
    output logic [31:0] wd_LO,
    output logic [1:0]  dbg_state
);

    localparam int unsigned      MUL_ITERS = mul_iters(MUL_RADIX_BITS);
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(MUL_ITERS);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS);

    md_state_e        state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: running product, or {remainder, quotient/dividend} during divide.
    logic [63:0]      acc_q, acc_d;
    // opnd: shifted multiplicand, or zero-extended divisor magnitude.
    logic [63:0]      opnd_q, opnd_d;
    logic [31:0]      mplier_q, mplier_d;

    logic        req_fire;
    logic [63:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic        prod_neg;
    logic        rem_neg;
    logic [63:0] prod_fixed;
    logic [63:0] div_fixed;
    logic [63:0] result;

    assign req_fire  = req_valid & req_ready;
    assign dbg_state = state_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latched op/operands, counter and accumulators.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            mplier_q <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            mplier_q <= mplier_d;
        end
    end

    // Next-state logic; cancel overrides everything and returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_fire) state_d = req_op[1] ? ST_DIV : ST_MUL;
            ST_MUL:  if (cnt_q == MUL_LAST) state_d = ST_DONE;
            ST_DIV:  if (cnt_q == DIV_LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (cancel) state_d = ST_IDLE;
    end

    // Datapath step: capture on accept, setup at count 0, then iterate.
    always_comb begin
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        mplier_d  = mplier_q;
        mul_sum   = acc_q;
        div_shift = acc_q[63:31];
        div_trial = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    op_d     = req_op;
                    a_d      = req_a;
                    b_d      = req_b;
                    cnt_d    = '0;
                    acc_d    = '0;
                    opnd_d   = '0;
                    mplier_d = '0;
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    acc_d    = '0;
                    opnd_d   = {32'd0, magnitude(a_q, op_q[0])};
                    mplier_d = magnitude(b_q, op_q[0]);
                end else begin
                    // Add the multiplicand once per set bit of the current digit.
                    for (int i = 0; i < int'(MUL_RADIX_BITS); i++) begin
                        if (mplier_q[i]) mul_sum = mul_sum + (opnd_q << i);
                    end
                    acc_d    = mul_sum;
                    opnd_d   = opnd_q << MUL_RADIX_BITS;
                    mplier_d = mplier_q >> MUL_RADIX_BITS;
                end
            end
            ST_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    acc_d  = {32'd0, magnitude(a_q, op_q[0])};
                    opnd_d = {32'd0, magnitude(b_q, op_q[0])};
                end else begin
                    // Restoring step: shift in next dividend bit, try subtract.
                    div_trial = div_shift - {1'b0, opnd_q[31:0]};
                    if (!div_trial[32]) begin
                        acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
                    end else begin
                        acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
                    end
                end
            end
            default: ;
        endcase
    end

    // Sign conditions: product/quotient follow sign mismatch, remainder the dividend.
    always_comb begin
        prod_neg = op_q[0] & (a_q[31] ^ b_q[31]);
        rem_neg  = op_q[0] & a_q[31];
    end

    muldiv_signfix u_prod_fix (
        .split  (1'b0),
        .neg_hi (prod_neg),
        .neg_lo (prod_neg),
        .din    (acc_q),
        .dout   (prod_fixed)
    );

    muldiv_signfix u_div_fix (
        .split  (1'b1),
        .neg_hi (rem_neg),
        .neg_lo (prod_neg),
        .din    (acc_q),
        .dout   (div_fixed)
    );

    // Final {HI, LO}; a zero divisor returns all-ones quotient and raw dividend.
    always_comb begin
        if (!op_q[1]) begin
            result = prod_fixed;
        end else if (b_q == 32'd0) begin
            result = {a_q, 32'hFFFF_FFFF};
        end else begin
            result = div_fixed;
        end
    end

    // Outputs: handshake, busy, and the one-cycle HI/LO write in DONE.
    always_comb begin
        req_ready = (state_q == ST_IDLE) & ~cancel;
        busy      = (state_q != ST_IDLE);
        we_HI     = 1'b0;
        we_LO     = 1'b0;
        wd_HI     = '0;
        wd_LO     = '0;
        if (state_q == ST_DONE && !cancel) begin
            we_HI = 1'b1;
            we_LO = 1'b1;
            wd_HI = result[63:32];
            wd_LO = result[31:0];
        end
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo: a behavioural HI/LO model built from plain
// arithmetic feeds an expectation queue checked every falling edge.
`timescale 1ns/1ps
module tb_muldiv_hilo;

    localparam int R = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        cancel = 1'b0;
    logic        req_ready;
    logic        busy;
    logic        we_HI, we_LO;
    logic [31:0] wd_HI, wd_LO;
    logic [1:0]  dbg_state;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc;
        int          due;
        bit          killed;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          last_we_cyc = -1;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    bit          run_chk = 1'b0;
    logic        e_busy, e_we;
    logic [31:0] e_hi, e_lo;

    muldiv_hilo #(.MUL_RADIX_BITS(R)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .cancel    (cancel),
        .busy      (busy),
        .we_HI     (we_HI),
        .we_LO     (we_LO),
        .wd_HI     (wd_HI),
        .wd_LO     (wd_LO),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference results from ordinary integer arithmetic; returns {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub;
        longint      sa, sb, q, r;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: return ua * ub;
            2'b01: return 64'(sa * sb);
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
        endcase
    endfunction

    function automatic int lat(input logic [1:0] op);
        return op[1] ? 33 : (32 / R + 1);
    endfunction

    // Present a request (optionally aligning to the next edge first); returns accept cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit sync, output int acc);
        exp_t        e;
        logic [63:0] m;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        #1;
        chk("req_ready_before_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc       = cyc;
        m         = model(op, a, b);
        e.hi      = m[63:32];
        e.lo      = m[31:0];
        e.acc     = cyc;
        e.due     = cyc + lat(op);
        e.killed  = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout at cycle %0d", cyc);
            exp_q.delete();
        end
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full operation with literal checks on the written HI/LO and the latency.
    task automatic run_lit(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                           input int latency);
        int acc;
        issue(op, a, b, 1'b1, acc);
        wait_idle();
        chk({name, "_hi"}, last_hi, hi);
        chk({name, "_lo"}, last_lo, lo);
        chk({name, "_latency"}, last_we_cyc - acc, latency);
    endtask

    // Scoreboard: compare every output on each falling edge against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            e_busy = 1'b0;
            e_we   = 1'b0;
            e_hi   = '0;
            e_lo   = '0;
            if (exp_q.size() > 0) begin
                e_busy = 1'b1;
                if (cyc == exp_q[0].due && !exp_q[0].killed) begin
                    e_we = 1'b1;
                    e_hi = exp_q[0].hi;
                    e_lo = exp_q[0].lo;
                end
            end
            chk("busy", busy, e_busy);
            chk("req_ready", req_ready, !e_busy && !cancel);
            chk("we_HI", we_HI, e_we);
            chk("we_LO", we_LO, e_we);
            chk("wd_HI", wd_HI, e_hi);
            chk("wd_LO", wd_LO, e_lo);
            if (we_HI) begin
                last_hi     = wd_HI;
                last_lo     = wd_LO;
                last_we_cyc = cyc;
            end
            if (exp_q.size() > 0 && cyc >= exp_q[0].due) void'(exp_q.pop_front());
        end
    end

    initial begin
        int acc;
        run_chk = 1'b1;

        // Pin the model against hand-computed values.
        chk("model_mult", model(2'b01, 32'hFFFF_FFFF, 32'h2), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("model_multu", model(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("model_div_neg7", model(2'b11, 32'hFFFF_FFF9, 32'h2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_div_ovf", model(2'b11, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("model_divu_zero", model(2'b10, 32'h1234, 32'h0), 64'h0000_1234_FFFF_FFFF);

        // Reset state, then release.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", req_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_we", we_HI | we_LO, 0);
        reset = 1'b0;

        // Directed operations with literal expectations.
        run_lit("mult_m1x2", 2'b01, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 17);
        run_lit("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 17);
        run_lit("div_neg7", 2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_lit("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        run_lit("divu_zero", 2'b10, 32'h1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 33);
        run_lit("div_zero", 2'b11, 32'h8000_0005, 32'h0, 32'h8000_0005, 32'hFFFF_FFFF, 33);
        run_lit("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 17);
        run_lit("div_7_m2", 2'b11, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 33);
        run_lit("divu_max_3", 2'b10, 32'hFFFF_FFFF, 32'h3, 32'h0, 32'h5555_5555, 33);
        run_lit("multu_0x10", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 17);

        // Further directed vectors checked by the scoreboard only.
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, acc); wait_idle();
        issue(2'b01, 32'h8765_4321, 32'h0FED_CBA9, 1'b1, acc); wait_idle();
        issue(2'b10, 32'hDEAD_BEEF, 32'h0000_1001, 1'b1, acc); wait_idle();
        issue(2'b11, 32'h8000_0001, 32'h0000_7FFF, 1'b1, acc); wait_idle();
        issue(2'b11, 32'h0000_0005, 32'hFFFF_FFF9, 1'b1, acc); wait_idle();

        // Cancel mid-divide, then a new request taken on the following cycle.
        issue(2'b10, 32'h0BAD_F00D, 32'h0000_0013, 1'b1, acc);
        wait_until(acc + 10);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        exp_q.delete();
        chk("cancel_busy_after", busy, 0);
        issue(2'b00, 32'h0000_0007, 32'h0000_0009, 1'b0, acc);
        wait_idle();
        chk("after_cancel_lo", last_lo, 32'd63);
        chk("after_cancel_latency", last_we_cyc - acc, 17);

        // Cancel landing in the DONE cycle suppresses the write.
        issue(2'b00, 32'h0000_0003, 32'h0000_0005, 1'b1, acc);
        wait_until(acc + 17);
        cancel = 1'b1;
        exp_q[0].killed = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        wait_idle();
        chk("done_cancel_no_write", last_we_cyc < acc + 17, 1);

        // Asynchronous reset in the middle of a multiply.
        issue(2'b01, 32'h0000_1111, 32'hFFFF_0000, 1'b1, acc);
        wait_until(acc + 6);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("async_reset_busy", busy, 0);
        chk("async_reset_ready", req_ready, 1);
        chk("async_reset_we", we_HI | we_LO, 0);
        chk("async_reset_wd", {wd_HI, wd_LO}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // req_valid together with cancel in IDLE must not be accepted.
        @(posedge clk);
        #1;
        req_op    = 2'b01;
        req_a     = 32'h5;
        req_b     = 32'h6;
        req_valid = 1'b1;
        cancel    = 1'b1;
        #1;
        chk("cancel_idle_ready", req_ready, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cancel    = 1'b0;
        chk("cancel_idle_not_taken", busy, 0);
        repeat (3) @(posedge clk);
        #1;

        // One more operation to show the unit is healthy afterwards.
        run_lit("final_mult", 2'b01, 32'hFFFF_FFFD, 32'h0000_0004, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 17);

        @(negedge clk);
        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
